// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared FSM state and op encodings for the stack pointer controller
package stack_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_XFER = 1'b1;

   localparam logic OP_PUSH = 1'b0;
   localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/stack_ptr_ctrl_if.sv
// rtl/stack_ptr_ctrl_if.sv - request, memory-strobe and status bundle of the stack pointer controller
interface stack_ptr_ctrl_if #(
   parameter int AW = 16,
   parameter int CW = 4,
   parameter int LW = 9
);
   logic          op_valid;
   logic          op_ready;
   logic          op_pop;
   logic [CW-1:0] op_count;
   logic          sp_load;
   logic [AW-1:0] sp_load_val;
   logic [AW-1:0] sp;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic          mem_re;
   logic          busy;
   logic          done;
   logic          op_err;
   logic [LW-1:0] level;
   logic          empty;
   logic          full;
   logic          ovf;
   logic          unf;
   logic          err_clr;

   modport master (
      output op_valid, op_pop, op_count, sp_load, sp_load_val, err_clr,
      input  op_ready, sp, mem_addr, mem_we, mem_re, busy, done, op_err,
             level, empty, full, ovf, unf
   );

   modport slave (
      input  op_valid, op_pop, op_count, sp_load, sp_load_val, err_clr,
      output op_ready, sp, mem_addr, mem_we, mem_re, busy, done, op_err,
             level, empty, full, ovf, unf
   );
endinterface

// File: rtl/stack_ptr_ctrl_sp_step.sv
// rtl/stack_ptr_ctrl_sp_step.sv - next SP and beat address for one push/pop beat (empty-descending stack)
module sp_step #(
   parameter int AW = 16
) (
   input  logic [AW-1:0] sp,
   input  logic          pop,
   output logic [AW-1:0] next_sp,
   output logic [AW-1:0] addr
);
   always_comb begin
      next_sp = pop ? sp + AW'(1) : sp - AW'(1);
      addr    = pop ? sp + AW'(1) : sp;
   end
endmodule

// File: rtl/stack_ptr_ctrl.sv
// rtl/stack_ptr_ctrl.sv - burst push/pop stack pointer controller with window checks and sticky errors
module stack_ptr_ctrl
   import stack_pkg::*;
#(
   parameter int            AW        = 16,
   parameter logic [AW-1:0] TOP       = 16'hFFFF,
   parameter int            DEPTH     = 256,
   parameter int            MAX_BURST = 8,
   parameter int            CW        = $clog2(MAX_BURST + 1),
   parameter int            LW        = $clog2(DEPTH + 1)
) (
   input logic              clk,
   input logic              reset,
   stack_ptr_ctrl_if.slave  bus
);
   localparam logic [AW-1:0] FULL_SP = AW'(TOP - AW'(DEPTH));

   logic [0:0]    state;
   logic [CW-1:0] cnt;
   logic          dir_pop;
   logic [AW-1:0] sp_q;
   logic [AW-1:0] mem_addr_q;
   logic          mem_we_q, mem_re_q, done_q, op_err_q, ovf_q, unf_q;
   logic          step_pop;
   logic [AW-1:0] step_sp, step_addr;
   logic [LW-1:0] level;
   logic          accept, push_rej, pop_rej;

   // In IDLE the step unit previews the first beat of the incoming request.
   assign step_pop = (state == ST_IDLE) ? bus.op_pop : dir_pop;

   sp_step #(.AW(AW)) u_step (
      .sp      (sp_q),
      .pop     (step_pop),
      .next_sp (step_sp),
      .addr    (step_addr)
   );

   assign level    = LW'(TOP - sp_q);
   assign accept   = bus.op_valid && bus.op_ready;
   assign push_rej = (bus.op_pop == OP_PUSH) && (32'(level) + 32'(bus.op_count) > 32'(DEPTH));
   assign pop_rej  = (bus.op_pop == OP_POP) && (32'(bus.op_count) > 32'(level));

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         dir_pop    <= OP_PUSH;
         sp_q       <= TOP;
         mem_addr_q <= TOP;
         mem_we_q   <= 1'b0;
         mem_re_q   <= 1'b0;
         done_q     <= 1'b0;
         op_err_q   <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         op_err_q <= 1'b0;
         mem_we_q <= 1'b0;
         mem_re_q <= 1'b0;
         if (bus.err_clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
         end
         if (state == ST_IDLE) begin
            if (bus.sp_load) begin
               sp_q <= bus.sp_load_val;
            end else if (accept) begin
               if (push_rej || pop_rej) begin
                  done_q   <= 1'b1;
                  op_err_q <= 1'b1;
                  if (pop_rej) unf_q <= 1'b1;
                  else         ovf_q <= 1'b1;
               end else if (bus.op_count == '0) begin
                  done_q <= 1'b1;
               end else begin
                  // First beat is issued on the accept edge itself.
                  state      <= ST_XFER;
                  cnt        <= bus.op_count;
                  dir_pop    <= bus.op_pop;
                  mem_addr_q <= step_addr;
                  mem_we_q   <= !step_pop;
                  mem_re_q   <= step_pop;
                  sp_q       <= step_sp;
               end
            end
         end else begin
            if (cnt == CW'(1)) begin
               state  <= ST_IDLE;
               done_q <= 1'b1;
            end else begin
               cnt        <= cnt - CW'(1);
               mem_addr_q <= step_addr;
               mem_we_q   <= !step_pop;
               mem_re_q   <= step_pop;
               sp_q       <= step_sp;
            end
         end
      end
   end

   assign bus.op_ready = (state == ST_IDLE) && !bus.sp_load;
   assign bus.busy     = (state == ST_XFER);
   assign bus.sp       = sp_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_re   = mem_re_q;
   assign bus.done     = done_q;
   assign bus.op_err   = op_err_q;
   assign bus.level    = level;
   assign bus.empty    = (sp_q == TOP);
   assign bus.full     = (sp_q == FULL_SP);
   assign bus.ovf      = ovf_q;
   assign bus.unf      = unf_q;
endmodule

// File: doc/stack_ptr_ctrl.md
Name: stack_ptr_ctrl

Overview:
Parametrised stack-pointer controller for the processor's hardware stack. It is the successor of the single-word push/pop SP register and runs on a single clock edge. It accepts burst push/pop requests of 1..MAX_BURST words (CALL/RET frames, multi-register save), generates one stack-memory address strobe per cycle, and keeps the SP register. It also checks overflow/underflow against a configured stack window before any pointer movement.

Parameters:
AW, 16, address/SP width
TOP, 16'hFFFF, SP reset value; empty-stack address; stack grows downward
DEPTH, 256, stack capacity in words; lowest valid slot is TOP-DEPTH+1
MAX_BURST, 8, max words per request
CW, $clog2(MAX_BURST+1), width of op_count
LW, $clog2(DEPTH+1), width of level

Ports:
clk  in  1  clock; all state changes on posedge clk only
reset  in  1  synchronous, active-high reset
op_valid  in  1  burst request valid
op_ready  out  1  high in IDLE; request accepted when op_valid && op_ready
op_pop  in  1  1 = pop, 0 = push
op_count  in  CW  words in burst, 0..MAX_BURST
sp_load  in  1  load SP (MOV SP,x)
sp_load_val  in  AW  value for sp_load
sp  out  AW  current stack pointer (next free slot)
mem_addr  out  AW  stack memory address for the current beat
mem_we  out  1  push beat: write mem[mem_addr]
mem_re  out  1  pop beat: read mem[mem_addr]
busy  out  1  burst in progress
done  out  1  one-cycle pulse when a request completes or is rejected
op_err  out  1  one-cycle pulse with done when a request was rejected
level  out  LW  words on stack = TOP - sp
empty  out  1  sp == TOP
full  out  1  sp == TOP - DEPTH
ovf  out  1  sticky overflow flag
unf  out  1  sticky underflow flag
err_clr  in  1  clears ovf/unf

Behaviour:
- Reset (synchronous, highest priority): sp=TOP, state IDLE, busy=0, done=0, op_err=0, mem_we=mem_re=0, ovf=unf=0, mem_addr=TOP.
- Empty-descending convention. Push beat: mem_addr=sp, mem_we=1, sp<=sp-1. Pop beat: mem_addr=sp+1, mem_re=1, sp<=sp+1. All arithmetic is modulo 2^AW.
- FSM IDLE -> XFER -> IDLE. A remaining-beat counter of width CW is loaded on accept.
- IDLE, accept with op_count=n:
  - Push with n > DEPTH-level, or pop with n > level: reject. sp is unchanged and there are no mem strobes. done=op_err=1 on the next cycle. ovf (push) or unf (pop) is set.
  - n=0: done=1 on the next cycle, no strobes, no error.
  - Otherwise go to XFER. Beats occur on the n consecutive cycles after the accept edge, one strobe per cycle. done pulses in the cycle after the last beat. op_ready is high again in that same cycle, so back-to-back bursts are possible.
- busy=1 exactly during XFER beats. op_ready = !busy && !done is not required: op_ready = (state==IDLE).
- sp_load is honoured only in IDLE. It takes priority over a simultaneous op_valid: the request is not accepted (op_ready forced 0 that cycle). During XFER, sp_load is ignored.
- sp_load_val is not range-checked. level, empty and full are computed from sp. A loaded sp outside the window gives level values that are modulo only and carry no meaning; the error checks use level as computed.
- Sticky flags: err_clr clears ovf/unf. If a new error and err_clr occur in the same cycle, set wins.
- Reset mid-burst aborts immediately. Remaining beats are dropped and no done pulse is generated.
- mem_addr, mem_we and mem_re are registered outputs driven by the FSM, valid in the beat cycle.

Decomposition:
- Shared package stack_pkg: state enum (ST_IDLE, ST_XFER) and the op encoding constants OP_PUSH=0, OP_POP=1.
- One natural sub-module, sp_step: combinational next-SP/next-address for push/pop. It is the successor of the old incrementer/decrementer and is parametrised by AW.

Test Plan:
1. Reset, then push n=3 (DEPTH=8, TOP=FFFF) -> mem_we on 3 cycles at addr FFFF,FFFE,FFFD; sp=FFFC; level=3; done 1 cycle later; op_err=0.
2. Pop n=3 from that state -> mem_re at FFFD,FFFE,FFFF; sp=FFFF; empty=1.
3. Push 5 then push 4 -> second request rejected: done+op_err pulse, ovf=1, sp stays FFFA, no mem_we. Then err_clr -> ovf=0.
4. Pop n=1 from empty -> unf=1, op_err pulse, sp=FFFF. err_clr asserted in the same cycle as a second failing pop -> unf stays 1.
5. sp_load=FFF0 together with op_valid in IDLE -> sp=FFF0 and the request is not accepted. sp_load during XFER -> ignored, burst completes normally.
6. Reset asserted at beat 2 of a 4-word push -> sp=FFFF, no further strobes, no done. Then push n=0 -> done with no strobes.
